sys_mem_arb: RTL and testbench
==============================

// Module: sys_mem_arb
// PURPOSE
//  Two-master arbiter sharing the single system-memory port between the video line buffer (m0, pixel fetch)
//  and a general master (m1, e.g. frame writer / debug). Grants in bursts with m0 urgency override, keeps the
//  slave-side command legal, tracks outstanding reads and steers returned read data back to the issuing master.
// PARAMETERS
//  SYS_MEM_DATA_W   32   data width of all sys_mem buses
//  SYS_MEM_ADDR_W   27   address width of all sys_mem buses
//  BURST_LEN        16   max accepted commands per grant when the other master is requesting (>=1)
//  MAX_PEND         8    max outstanding reads; depth of read-owner tag FIFO (power of 2)
// PORTS
//  clk              in   1     system clock
//  rst_n            in   1     async active-low reset
//  m0_urgent        in   1     m0 buffer below low-water mark; raises m0 priority
//  mX_wren/mX_rden  in   1     master X (X=0,1) write/read command; held until accepted
//  mX_addr          in   ADDR  master X address;  mX_wdata in DATA master X write data
//  mX_wait          out  1     master X stall; command accepted when mX_(wr|rd)en & ~mX_wait
//  mX_rd_valid      out  1     read data valid for master X;  mX_rdata out DATA (shared sys_mem_rdata)
//  sys_mem_wait     in   1     slave stall
//  sys_mem_wren/rden out 1     slave write/read command
//  sys_mem_addr     out  ADDR  slave address;  sys_mem_wdata out DATA slave write data
//  sys_mem_rd_valid in   1     slave read data valid (in-order);  sys_mem_rdata in DATA
//  err_orphan       out  1     sticky: rd_valid with no outstanding read
// BEHAVIOUR
//  - Reset: state IDLE, last_owner=1, beat_cnt=0, tag FIFO empty, err_orphan=0; all outputs 0 except mX_wait=1.
//  - mX_req = mX_wren|mX_rden. States IDLE, GNT0, GNT1 (registered). Commands pass only in GNTx.
//  - IDLE: if m0_req & (m0_urgent | ~m1_req | last_owner==1) -> GNT0; else if m1_req -> GNT1; else stay.
//    1-cycle arbitration latency: command from IDLE reaches slave the cycle after grant is taken.
//  - GNTx: sys_mem_{wren,rden,addr,wdata} = master X signals (combinational); mX_wait = sys_mem_wait | rd_block;
//    other master wait=1. Accept = issued cmd & ~sys_mem_wait. beat_cnt increments per accept, cleared on grant.
//  - rd_block: mX_rden & tag FIFO full -> sys_mem_rden forced 0, mX_wait=1 (writes unaffected).
//  - Leave GNTx -> IDLE (last_owner<=X) only on command boundary = no issued cmd, or issued cmd accepted this cycle:
//    a) ~mX_req; b) accept with beat_cnt==BURST_LEN-1 and other master requesting; c) GNT1 and m0_urgent & m0_req.
//    Never deassert/alter an issued slave command while sys_mem_wait=1.
//  - BURST_LEN boundary with other master idle: keep grant, beat_cnt wraps to 0.
//  - Tag FIFO: push owner X on accepted read; pop on sys_mem_rd_valid, assert m<tag>_rd_valid same cycle
//    (combinational, zero latency). Simultaneous push+pop: count unchanged. Full reached only at MAX_PEND.
//  - sys_mem_rd_valid with FIFO empty: no mX_rd_valid, err_orphan<=1 (sticky until reset).
//  - Grant changes while reads outstanding are legal; returns still route by tag.
//  - Async reset mid-operation: immediate return to reset values; outstanding tags discarded.
// TESTING
//  1 m0 reads only, 20 cmds, wait=0, 3-cycle read latency -> IDLE->GNT0 once, 20 m0_rd_valid, m1_rd_valid=0.
//  2 m0 and m1 continuous reads, urgent=0, BURST_LEN=16 -> alternating 16-accept bursts, first grant to m0.
//  3 m1 mid-burst (beat 5), m0_urgent=1 with sys_mem_wait=1 for 3 cycles -> m1 cmd held stable until accept, then GNT0.
//  4 slave withholds rd_valid, m0 issues 10 reads -> 8 accepted, sys_mem_rden=0 and m0_wait=1 until first rd_valid.
//  5 interleaved m0/m1 reads with variable latency -> every returned word reaches the issuer in issue order.
//  6 sys_mem_rd_valid pulse at idle -> err_orphan=1 and stays 1; rst_n low mid-burst -> all outputs at reset values.

Source files
------------

// File: rtl/sys_mem_arb.sv
// sys_mem_arb: two-master burst arbiter for the shared system-memory port.
// m0 (video line fetch) can preempt m1 when urgent; read data is routed back by a tag FIFO.
module sys_mem_arb #(
  parameter int SYS_MEM_DATA_W = 32,
  parameter int SYS_MEM_ADDR_W = 27,
  parameter int BURST_LEN      = 16,
  parameter int MAX_PEND       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m0_urgent,
  input  logic                      m0_wren,
  input  logic                      m0_rden,
  input  logic [SYS_MEM_ADDR_W-1:0] m0_addr,
  input  logic [SYS_MEM_DATA_W-1:0] m0_wdata,
  output logic                      m0_wait,
  output logic                      m0_rd_valid,
  output logic [SYS_MEM_DATA_W-1:0] m0_rdata,
  input  logic                      m1_wren,
  input  logic                      m1_rden,
  input  logic [SYS_MEM_ADDR_W-1:0] m1_addr,
  input  logic [SYS_MEM_DATA_W-1:0] m1_wdata,
  output logic                      m1_wait,
  output logic                      m1_rd_valid,
  output logic [SYS_MEM_DATA_W-1:0] m1_rdata,
  input  logic                      sys_mem_wait,
  output logic                      sys_mem_wren,
  output logic                      sys_mem_rden,
  output logic [SYS_MEM_ADDR_W-1:0] sys_mem_addr,
  output logic [SYS_MEM_DATA_W-1:0] sys_mem_wdata,
  input  logic                      sys_mem_rd_valid,
  input  logic [SYS_MEM_DATA_W-1:0] sys_mem_rdata,
  output logic                      err_orphan
);

  localparam int PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t state, state_nx;
  logic last_owner, last_owner_nx;
  logic [BW-1:0] beat_cnt, beat_nx;

  logic tag_mem [MAX_PEND];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic full, empty, push, pop, pop_tag;

  logic m0_req, m1_req;
  logic own, own_req, oth_req;
  logic sel_wren, sel_rden;
  logic [SYS_MEM_ADDR_W-1:0] sel_addr;
  logic [SYS_MEM_DATA_W-1:0] sel_wdata;
  logic rd_block, issued, accept, last_beat, leave;

  assign m0_req = m0_wren | m0_rden;
  assign m1_req = m1_wren | m1_rden;
  assign full = (count == (PW+1)'(MAX_PEND));
  assign empty = (count == '0);
  assign last_beat = (beat_cnt == BW'(BURST_LEN - 1));

  assign pop = sys_mem_rd_valid & ~empty;
  assign pop_tag = tag_mem[rd_ptr];
  assign m0_rd_valid = pop & ~pop_tag;
  assign m1_rd_valid = pop & pop_tag;
  assign m0_rdata = sys_mem_rdata;
  assign m1_rdata = sys_mem_rdata;

  always_comb begin
    state_nx = state;
    last_owner_nx = last_owner;
    beat_nx = beat_cnt;
    own = 1'b0;
    own_req = 1'b0;
    oth_req = 1'b0;
    sel_wren = 1'b0;
    sel_rden = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    rd_block = 1'b0;
    issued = 1'b0;
    accept = 1'b0;
    leave = 1'b0;
    push = 1'b0;
    sys_mem_wren = 1'b0;
    sys_mem_rden = 1'b0;
    sys_mem_addr = '0;
    sys_mem_wdata = '0;
    m0_wait = 1'b1;
    m1_wait = 1'b1;
    unique case (state)
      IDLE: begin
        if (m0_req & (m0_urgent | ~m1_req | last_owner)) begin
          state_nx = GNT0;
          beat_nx = '0;
        end else if (m1_req) begin
          state_nx = GNT1;
          beat_nx = '0;
        end
      end
      GNT0, GNT1: begin
        own = (state == GNT1);
        own_req = own ? m1_req : m0_req;
        oth_req = own ? m0_req : m1_req;
        sel_wren = own ? m1_wren : m0_wren;
        sel_rden = own ? m1_rden : m0_rden;
        sel_addr = own ? m1_addr : m0_addr;
        sel_wdata = own ? m1_wdata : m0_wdata;
        // a full tag FIFO holds back reads only; writes still flow
        rd_block = sel_rden & full;
        sys_mem_wren = sel_wren;
        sys_mem_rden = sel_rden & ~full;
        sys_mem_addr = sel_addr;
        sys_mem_wdata = sel_wdata;
        issued = sys_mem_wren | sys_mem_rden;
        accept = issued & ~sys_mem_wait;
        push = accept & sys_mem_rden;
        if (own) m1_wait = sys_mem_wait | rd_block;
        else     m0_wait = sys_mem_wait | rd_block;
        if (accept) beat_nx = last_beat ? '0 : beat_cnt + BW'(1);
        // only release on a command boundary so a stalled command never changes
        leave = (~issued | accept) &
                (~own_req | (accept & last_beat & oth_req) |
                 (own & m0_urgent & m0_req));
        if (leave) begin
          state_nx = IDLE;
          last_owner_nx = own;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_owner <= 1'b1;
      beat_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err_orphan <= 1'b0;
    end else begin
      state <= state_nx;
      last_owner <= last_owner_nx;
      beat_cnt <= beat_nx;
      if (push)
        wr_ptr <= (wr_ptr == PW'(MAX_PEND - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PW'(MAX_PEND - 1)) ? '0 : rd_ptr + PW'(1);
      if (push & ~pop) count <= count + (PW+1)'(1);
      else if (pop & ~push) count <= count - (PW+1)'(1);
      if (sys_mem_rd_valid & empty) err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= own;
  end

endmodule

// File: tb/tb_sys_mem_arb.sv
// tb_sys_mem_arb: randomized masters and slave around sys_mem_arb,
// checked against a queue-based model of issue order and read routing.
module tb_sys_mem_arb;
  localparam int DW = 32;
  localparam int AW = 27;
  localparam int BL = 16;
  localparam int MP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_urgent = 1'b0;
  logic m0_wren = 1'b0, m0_rden = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic m0_wait, m0_rd_valid;
  logic [DW-1:0] m0_rdata;
  logic m1_wren = 1'b0, m1_rden = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic m1_wait, m1_rd_valid;
  logic [DW-1:0] m1_rdata;
  logic sys_mem_wait = 1'b0;
  logic sys_mem_wren, sys_mem_rden;
  logic [AW-1:0] sys_mem_addr;
  logic [DW-1:0] sys_mem_wdata;
  logic sys_mem_rd_valid = 1'b0;
  logic [DW-1:0] sys_mem_rdata = '0;
  logic err_orphan;

  always #5 clk = ~clk;

  sys_mem_arb #(
    .SYS_MEM_DATA_W(DW), .SYS_MEM_ADDR_W(AW),
    .BURST_LEN(BL), .MAX_PEND(MP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m0_urgent(m0_urgent),
    .m0_wren(m0_wren), .m0_rden(m0_rden), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wait(m0_wait),
    .m0_rd_valid(m0_rd_valid), .m0_rdata(m0_rdata),
    .m1_wren(m1_wren), .m1_rden(m1_rden), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wait(m1_wait),
    .m1_rd_valid(m1_rd_valid), .m1_rdata(m1_rdata),
    .sys_mem_wait(sys_mem_wait), .sys_mem_wren(sys_mem_wren),
    .sys_mem_rden(sys_mem_rden), .sys_mem_addr(sys_mem_addr),
    .sys_mem_wdata(sys_mem_wdata),
    .sys_mem_rd_valid(sys_mem_rd_valid),
    .sys_mem_rdata(sys_mem_rdata), .err_orphan(err_orphan)
  );

  typedef struct {
    bit wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    logic [AW-1:0] addr;
    int ready;
  } ret_t;

  cmd_t src0[$], src1[$];
  logic [AW-1:0] exp0[$], exp1[$];
  ret_t slv_q[$];
  int acc_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc0, acc1, rv0, rv1, stall0, stall1;
  int wait_pct = 0, force_wait = 0, lat_min = 1, lat_max = 1;
  bit ret_hold = 0, orphan_pulse = 0, urgent = 0;

  function automatic logic [DW-1:0] rdat(input logic [AW-1:0] a);
    return {a[4:0], a} ^ 32'h5A5A0F0F;
  endfunction

  function automatic cmd_t rnd_cmd(input bit wr);
    cmd_t c;
    c.wr = wr;
    c.addr = AW'($urandom);
    c.data = $urandom;
    return c;
  endfunction

  function automatic int pending();
    return src0.size() + src1.size() + exp0.size() +
           exp1.size() + slv_q.size();
  endfunction

  // one bus cycle: drive masters and slave, then check routing/acceptance
  task automatic step();
    bit a0, a1, sa, legit;
    logic [AW-1:0] ea;
    ret_t r;
    @(negedge clk);
    if (src0.size() > 0) begin
      m0_wren = src0[0].wr; m0_rden = !src0[0].wr;
      m0_addr = src0[0].addr; m0_wdata = src0[0].data;
    end else begin
      m0_wren = 1'b0; m0_rden = 1'b0;
    end
    if (src1.size() > 0) begin
      m1_wren = src1[0].wr; m1_rden = !src1[0].wr;
      m1_addr = src1[0].addr; m1_wdata = src1[0].data;
    end else begin
      m1_wren = 1'b0; m1_rden = 1'b0;
    end
    m0_urgent = urgent;
    if (force_wait > 0) begin
      sys_mem_wait = 1'b1;
      force_wait--;
    end else begin
      sys_mem_wait = (int'($urandom_range(99)) < wait_pct);
    end
    sys_mem_rd_valid = 1'b0;
    sys_mem_rdata = $urandom;
    legit = 0;
    if (orphan_pulse) begin
      sys_mem_rd_valid = 1'b1;
      orphan_pulse = 0;
    end else if (!ret_hold && slv_q.size() > 0 &&
                 slv_q[0].ready <= cyc) begin
      r = slv_q.pop_front();
      sys_mem_rd_valid = 1'b1;
      sys_mem_rdata = rdat(r.addr);
      legit = 1;
    end
    #2;
    checks++;
    if (int'(m0_rd_valid) + int'(m1_rd_valid) != (legit ? 1 : 0)) begin
      errors++;
      $display("FAIL route_valid cyc=%0d got m0=%b m1=%b want %0d",
               cyc, m0_rd_valid, m1_rd_valid, legit);
    end
    if (m0_rd_valid === 1'b1) begin
      rv0++;
      checks++;
      if (exp0.size() == 0) begin
        errors++;
        $display("FAIL m0_rd_extra cyc=%0d got valid want none", cyc);
      end else begin
        ea = exp0.pop_front();
        if (m0_rdata !== rdat(ea)) begin
          errors++;
          $display("FAIL m0_rdata cyc=%0d got %h want %h",
                   cyc, m0_rdata, rdat(ea));
        end
      end
    end
    if (m1_rd_valid === 1'b1) begin
      rv1++;
      checks++;
      if (exp1.size() == 0) begin
        errors++;
        $display("FAIL m1_rd_extra cyc=%0d got valid want none", cyc);
      end else begin
        ea = exp1.pop_front();
        if (m1_rdata !== rdat(ea)) begin
          errors++;
          $display("FAIL m1_rdata cyc=%0d got %h want %h",
                   cyc, m1_rdata, rdat(ea));
        end
      end
    end
    a0 = (m0_wren | m0_rden) & (m0_wait === 1'b0);
    a1 = (m1_wren | m1_rden) & (m1_wait === 1'b0);
    sa = (sys_mem_wren | sys_mem_rden) & !sys_mem_wait;
    if ((m0_wren | m0_rden) && m0_wait) stall0++;
    if ((m1_wren | m1_rden) && m1_wait) stall1++;
    checks++;
    if (sa !== (a0 | a1) || (a0 && a1)) begin
      errors++;
      $display("FAIL accept cyc=%0d got slave=%b m0=%b m1=%b want slave==m0|m1 single",
               cyc, sa, a0, a1);
    end
    if (a0) begin
      checks++;
      if ({sys_mem_wren, sys_mem_rden, sys_mem_addr} !==
          {src0[0].wr, !src0[0].wr, src0[0].addr} ||
          (src0[0].wr && sys_mem_wdata !== src0[0].data)) begin
        errors++;
        $display("FAIL cmd0 cyc=%0d got a=%h w=%b want a=%h w=%b",
                 cyc, sys_mem_addr, sys_mem_wren, src0[0].addr, src0[0].wr);
      end
      if (!src0[0].wr) begin
        exp0.push_back(src0[0].addr);
        r.addr = src0[0].addr;
        r.ready = cyc + int'($urandom_range(lat_max, lat_min));
        slv_q.push_back(r);
      end
      void'(src0.pop_front());
      acc0++;
      acc_log.push_back(0);
    end
    if (a1) begin
      checks++;
      if ({sys_mem_wren, sys_mem_rden, sys_mem_addr} !==
          {src1[0].wr, !src1[0].wr, src1[0].addr} ||
          (src1[0].wr && sys_mem_wdata !== src1[0].data)) begin
        errors++;
        $display("FAIL cmd1 cyc=%0d got a=%h w=%b want a=%h w=%b",
                 cyc, sys_mem_addr, sys_mem_wren, src1[0].addr, src1[0].wr);
      end
      if (!src1[0].wr) begin
        exp1.push_back(src1[0].addr);
        r.addr = src1[0].addr;
        r.ready = cyc + int'($urandom_range(lat_max, lat_min));
        slv_q.push_back(r);
      end
      void'(src1.pop_front());
      acc1++;
      acc_log.push_back(1);
    end
    checks++;
    if (exp0.size() + exp1.size() > MP) begin
      errors++;
      $display("FAIL outstanding cyc=%0d got %0d want <=%0d",
               cyc, exp0.size() + exp1.size(), MP);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src0.delete(); src1.delete();
    exp0.delete(); exp1.delete();
    slv_q.delete();
    urgent = 0; force_wait = 0; ret_hold = 0; orphan_pulse = 0;
    wait_pct = 0; lat_min = 1; lat_max = 1;
    repeat (2) step();
    acc_log.delete();
    acc0 = 0; acc1 = 0; rv0 = 0; rv1 = 0; stall0 = 0; stall1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int maxc, input string nm);
    int n = 0;
    while (pending() > 0 && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending want 0", nm, pending());
    end
  endtask

  task automatic expect_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    checks++;
    if (m0_wait !== 1'b1 || m1_wait !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait got %b%b want 11", nm, m0_wait, m1_wait);
    end
    checks++;
    if ({sys_mem_wren, sys_mem_rden} !== 2'b00 ||
        sys_mem_addr !== '0 || sys_mem_wdata !== '0) begin
      errors++;
      $display("FAIL %s_slave got wr=%b rd=%b a=%h want 0",
               nm, sys_mem_wren, sys_mem_rden, sys_mem_addr);
    end
    checks++;
    if ({m0_rd_valid, m1_rd_valid, err_orphan} !== 3'b000) begin
      errors++;
      $display("FAIL %s_flags got %b%b%b want 000",
               nm, m0_rd_valid, m1_rd_valid, err_orphan);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_m0_reads();
    int n = 0;
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20; i++) src0.push_back(rnd_cmd(0));
    while (acc0 < 20 && n < 200) begin step(); n++; end
    drain(200, "m0_reads");
    expect_int("m0_reads_acc", acc0, 20);
    expect_int("m0_reads_rv0", rv0, 20);
    expect_int("m0_reads_rv1", rv1, 0);
    expect_int("m0_reads_stall", stall0, 1);
  endtask

  task automatic test_bursts();
    int n = 0;
    int v;
    do_reset();
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 64; i++) begin
      src0.push_back(rnd_cmd(0));
      src1.push_back(rnd_cmd(0));
    end
    while (acc_log.size() < 128 && n < 400) begin step(); n++; end
    drain(200, "bursts");
    expect_int("bursts_total", acc_log.size(), 128);
    for (int k = 0; k < 128; k++) begin
      v = (k < acc_log.size()) ? acc_log[k] : -1;
      checks++;
      if (v != (k / BL) % 2) begin
        errors++;
        $display("FAIL burst_owner k=%0d got %0d want %0d", k, v, (k / BL) % 2);
      end
    end
  endtask

  task automatic test_urgent_preempt();
    int n = 0;
    logic [AW-1:0] hold;
    do_reset();
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 20; i++) src1.push_back(rnd_cmd(0));
    while (acc1 < 5 && n < 50) begin step(); n++; end
    hold = src1[0].addr;
    for (int i = 0; i < 4; i++) src0.push_back(rnd_cmd(0));
    urgent = 1;
    force_wait = 3;
    repeat (3) begin
      step();
      checks++;
      if (sys_mem_rden !== 1'b1 || sys_mem_addr !== hold ||
          m1_wait !== 1'b1 || m0_wait !== 1'b1) begin
        errors++;
        $display("FAIL preempt_hold got rd=%b a=%h w1=%b w0=%b want 1 %h 1 1",
                 sys_mem_rden, sys_mem_addr, m1_wait, m0_wait, hold);
      end
    end
    n = 0;
    while (acc_log.size() < 7 && n < 30) begin step(); n++; end
    expect_int("preempt_m1_6th", (acc_log.size() > 5) ? acc_log[5] : -1, 1);
    expect_int("preempt_m0_next", (acc_log.size() > 6) ? acc_log[6] : -1, 0);
    urgent = 0;
    drain(300, "preempt");
  endtask

  task automatic test_fifo_full();
    int pa, pr, rvc, ac9, n;
    do_reset();
    ret_hold = 1;
    for (int i = 0; i < 10; i++) src0.push_back(rnd_cmd(0));
    repeat (30) begin
      pa = acc0; pr = rv0;
      step();
      if (pa == MP && pr == 0) begin
        checks++;
        if (sys_mem_rden !== 1'b0 || m0_wait !== 1'b1) begin
          errors++;
          $display("FAIL full_block got rden=%b wait=%b want 0 1",
                   sys_mem_rden, m0_wait);
        end
      end
    end
    expect_int("full_acc", acc0, MP);
    ret_hold = 0;
    rvc = -1; ac9 = -2; n = 0;
    while (acc0 < 10 && n < 50) begin
      pa = acc0; pr = rv0;
      step();
      if (pr == 0 && rv0 > 0) rvc = cyc;
      if (pa < MP + 1 && acc0 >= MP + 1) ac9 = cyc;
      n++;
    end
    expect_int("full_release_cycle", ac9, rvc + 1);
    drain(100, "full");
    expect_int("full_rv0", rv0, 10);
  endtask

  task automatic test_random();
    do_reset();
    wait_pct = 30; lat_min = 1; lat_max = 6;
    for (int i = 0; i < 60; i++) begin
      src0.push_back(rnd_cmd(1'($urandom_range(1))));
      src1.push_back(rnd_cmd(1'($urandom_range(1))));
    end
    repeat (400) begin
      urgent = ($urandom_range(3) == 0);
      ret_hold = ($urandom_range(7) == 0);
      step();
    end
    urgent = 0;
    ret_hold = 0;
    drain(3000, "random");
    expect_int("random_acc0", acc0, 60);
    expect_int("random_acc1", acc1, 60);
    expect_int("random_orphan", int'(err_orphan), 0);
  endtask

  task automatic test_orphan_and_reset();
    int n = 0;
    do_reset();
    repeat (2) step();
    expect_int("orphan_before", int'(err_orphan), 0);
    orphan_pulse = 1;
    step();
    step();
    expect_int("orphan_set", int'(err_orphan), 1);
    repeat (5) step();
    expect_int("orphan_sticky", int'(err_orphan), 1);
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20; i++) src0.push_back(rnd_cmd(0));
    while (acc0 < 4 && n < 50) begin step(); n++; end
    rst_n = 1'b0;
    sys_mem_rd_valid = 1'b1;
    #1;
    check_reset_outputs("midreset");
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_m0_reads();
    test_bursts();
    test_urgent_preempt();
    test_fifo_full();
    test_random();
    test_orphan_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
